// File: rtl/neurex_pkg.sv
// neurex_pkg: types and helpers shared by the output-memory read path.
//   state_e           : read-controller FSM state (2-bit)
//   log2_pow2()       : log2 of a power-of-two size, usable in constant context
//   SYS_COL_DEF       : default number of output memory banks
//   SYS_COL_LOG2_DEF  : log2 of the default bank count
package neurex_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int log2_pow2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int SYS_COL_DEF      = 16;
  localparam int SYS_COL_LOG2_DEF = log2_pow2(SYS_COL_DEF);

endpackage

// File: rtl/out_skid_fifo.sv
// out_skid_fifo: 2-entry FIFO of SYS_COL x PSUM_WIDTH words that absorbs the
// one-cycle memory read latency against downstream backpressure.
//   clk, rstn  : clock, synchronous active-low reset
//   push       : store push_data this cycle
//   push_data  : incoming word (straight from the memory banks)
//   pop        : drop the head entry this cycle (ignored when empty)
//   head_data  : oldest stored word, driven from registers only
//   occ        : number of stored words (0..2)
module out_skid_fifo #(
  parameter int SYS_COL    = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [PSUM_WIDTH-1:0] push_data [0:SYS_COL-1],
  input  logic                  pop,
  output logic [PSUM_WIDTH-1:0] head_data [0:SYS_COL-1],
  output logic [1:0]            occ
);

  logic [PSUM_WIDTH-1:0] entry_q [0:1][0:SYS_COL-1];
  logic [PSUM_WIDTH-1:0] entry_d [0:1][0:SYS_COL-1];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop_ok;

  assign pop_ok = pop && (occ_q != 2'd0);

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      for (int j = 0; j < SYS_COL; j++) entry_d[wr_ptr_q][j] = push_data[j];
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_ok) rd_ptr_d = ~rd_ptr_q;
    // simultaneous push and pop leaves the count unchanged
    case ({push, pop_ok})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < SYS_COL; j++) entry_q[i][j] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    for (int j = 0; j < SYS_COL; j++) head_data[j] = entry_q[rd_ptr_q][j];
  end

  assign occ = occ_q;

endmodule

// File: rtl/out_mem_rd_ctrl.sv
// out_mem_rd_ctrl: walks the output memory in linear address order after a
// layer completes and streams each SYS_COL-wide word over valid/ready.
//   clk, rstn     : clock, synchronous active-low reset
//   start         : begin draining (sampled in IDLE only)
//   num_in        : number of output rows
//   num_out       : number of output columns (words per row = num_out/SYS_COL)
//   mem_rd_en     : bank read enables (all bits equal)
//   mem_rd_addr   : bank read addresses (all entries equal, 0 when idle)
//   mem_rd_data   : bank read data, one cycle after mem_rd_en
//   out_valid     : out_data holds a word
//   out_ready     : consumer takes the word
//   out_data      : streamed word (0 when out_valid is low)
//   out_last      : final word of the transfer
//   busy          : transfer in progress
//   done          : one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start; size latched on start
// STREAM | issuing reads and draining the skid FIFO
// DONE   | one-cycle done pulse, then back to IDLE
module out_mem_rd_ctrl
  import neurex_pkg::*;
#(
  parameter  int SYS_COL    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 16,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] num_out,
  output logic [SYS_COL-1:0]    mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr [0:SYS_COL-1],
  input  logic [PSUM_WIDTH-1:0] mem_rd_data [0:SYS_COL-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_data [0:SYS_COL-1],
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_SHIFT = log2_pow2(SYS_COL);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] total_q, total_d;
  logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
  logic [ADDR_WIDTH-1:0] sent_cnt_q, sent_cnt_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] words_per_row;
  logic [ADDR_WIDTH-1:0] total_new;
  logic [PSUM_WIDTH-1:0] head_data [0:SYS_COL-1];
  logic [1:0]            occ;
  logic [2:0]            fill;
  logic                  pop;
  logic                  rd_issue;
  logic                  is_last;

  // Product taken modulo 2^ADDR_WIDTH; truncating the operands first gives
  // the same low bits as truncating the full-width product.
  assign words_per_row = num_out >> COL_SHIFT;
  assign total_new     = ADDR_WIDTH'(num_in) * ADDR_WIDTH'(words_per_row);

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  assign is_last   = (sent_cnt_q == total_q - ADDR_WIDTH'(1));
  assign out_last  = out_valid && is_last;

  // Words held or owed to the FIFO after this cycle's pop; a new read may
  // only be issued if it still fits in the two entries.
  assign fill     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == STREAM) && (issue_addr_q < total_q) && (fill < 3'd2);

  out_skid_fifo #(
    .SYS_COL    (SYS_COL),
    .PSUM_WIDTH (PSUM_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    issue_addr_d = issue_addr_q;
    sent_cnt_d   = sent_cnt_q;
    inflight_d   = rd_issue;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          total_d      = total_new;
          issue_addr_d = '0;
          sent_cnt_d   = '0;
          state_d      = (total_new == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (rd_issue) issue_addr_d = issue_addr_q + ADDR_WIDTH'(1);
        if (pop) begin
          sent_cnt_d = sent_cnt_q + ADDR_WIDTH'(1);
          if (is_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      total_q      <= '0;
      issue_addr_q <= '0;
      sent_cnt_q   <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      issue_addr_q <= issue_addr_d;
      sent_cnt_q   <= sent_cnt_d;
      inflight_q   <= inflight_d;
    end
  end

  always_comb begin
    mem_rd_en = {SYS_COL{rd_issue}};
    for (int j = 0; j < SYS_COL; j++) begin
      mem_rd_addr[j] = rd_issue ? issue_addr_q : '0;
      out_data[j]    = out_valid ? head_data[j] : '0;
    end
  end

  assign busy = (state_q == STREAM);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_out_mem_rd_ctrl.sv
module tb_out_mem_rd_ctrl;

  localparam int NC = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [15:0]   num_in;
  logic [15:0]   num_out;
  logic [NC-1:0] mem_rd_en;
  logic [15:0]   mem_rd_addr [0:NC-1];
  logic [PW-1:0] mem_rd_data [0:NC-1];
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_data [0:NC-1];
  logic          out_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  out_mem_rd_ctrl #(
    .SYS_COL    (NC),
    .DATA_WIDTH (16),
    .ADDR_WIDTH (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .num_in      (num_in),
    .num_out     (num_out),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Content of bank j at address a.
  function automatic logic [PW-1:0] word_val(input int a, input int j);
    return {a[15:0], j[7:0], 8'(a * 7 + j)};
  endfunction

  // Memory: data one cycle after a read; junk when nothing was read.
  always @(posedge clk) begin
    for (int j = 0; j < NC; j++)
      mem_rd_data[j] <= mem_rd_en[0] ? word_val(int'(mem_rd_addr[0]), j) : PW'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    for (int j = 0; j < NC; j++) begin
      check({tag, "_rd_addr"}, mem_rd_addr[j], 0);
      check({tag, "_data"}, out_data[j], 0);
    end
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One transfer checked cycle by cycle against a count-based model:
  // words owed to the consumer = issued - accepted, of which the read issued
  // last cycle is still in flight; a read goes out while words remain and
  // (issued - accepted - this cycle's pop) < 2.
  task automatic run_xfer(input string name, input int ni, input int no, input bit rnd,
                          input int abort_after, input int restart_at);
    int total, issued, accepted, first_v, done_cyc;
    bit inflight, stream, done_now, done_next, finished;
    bit exp_valid, exp_pop, exp_issue, exp_last, prev_stall;
    logic [PW-1:0] prev_d0, prev_d15;
    total = (ni * (no / NC)) % 65536;
    num_in  = 16'(ni);
    num_out = 16'(no);
    start = 1'b1;
    out_ready = 1'b1;
    #1;
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_done"}, done, 0);
    check({name, "_idle_valid"}, out_valid, 0);
    check({name, "_idle_rd_en"}, mem_rd_en, 0);
    @(posedge clk); #1;
    start = 1'b0;
    issued = 0; accepted = 0; inflight = 0;
    stream = (total != 0); done_now = (total == 0);
    finished = 0; first_v = -1; done_cyc = -1; prev_stall = 0;
    prev_d0 = '0; prev_d15 = '0;
    for (int cyc = 0; cyc < 30 + 6 * total && !finished; cyc++) begin
      if (abort_after >= 0 && accepted == abort_after) begin
        rstn = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        check_all_zero({name, "_abort"});
        return;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == restart_at);
      if (start) num_in = 16'(ni + 3);
      #1;
      exp_valid = (issued - int'(inflight) - accepted) > 0;
      exp_pop   = exp_valid && out_ready;
      exp_issue = stream && (issued < total) && ((issued - accepted - int'(exp_pop)) < 2);
      exp_last  = exp_valid && (accepted == total - 1);
      check({name, "_rd_en"}, mem_rd_en, exp_issue ? {NC{1'b1}} : '0);
      if (exp_issue)
        for (int j = 0; j < NC; j++) check({name, "_rd_addr"}, mem_rd_addr[j], issued);
      check({name, "_valid"}, out_valid, exp_valid);
      check({name, "_last"}, out_last, exp_last);
      if (exp_valid)
        for (int j = 0; j < NC; j++) check({name, "_data"}, out_data[j], word_val(accepted, j));
      if (prev_stall) begin
        check({name, "_stall_d0"}, out_data[0], prev_d0);
        check({name, "_stall_d15"}, out_data[NC-1], prev_d15);
      end
      check({name, "_busy"}, busy, stream);
      check({name, "_done"}, done, done_now);
      if (exp_valid && first_v < 0) first_v = cyc;
      if (done_now) begin
        done_cyc = cyc;
        finished = 1;
      end
      prev_stall = exp_valid && !out_ready;
      prev_d0    = out_data[0];
      prev_d15   = out_data[NC-1];
      done_next  = exp_pop && exp_last;
      if (done_next) stream = 0;
      if (exp_pop) accepted++;
      inflight = exp_issue;
      if (exp_issue) issued++;
      done_now = done_next;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({name, "_completed"}, finished, 1);
    check({name, "_reads"}, issued, total);
    check({name, "_beats"}, accepted, total);
    if (!rnd && total > 0 && restart_at < 0) begin
      check({name, "_first_valid_cyc"}, first_v, 2);
      check({name, "_done_cyc"}, done_cyc, total + 2);
    end
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    num_in = '0;
    num_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    run_xfer("basic",      4,   32, 1'b0, -1, -1);
    run_xfer("backpress",  4,   32, 1'b1, -1, -1);
    run_xfer("zero_rows",  0,   32, 1'b0, -1, -1);
    run_xfer("zero_cols",  4,    8, 1'b0, -1, -1);
    run_xfer("trunc_zero", 4096, 256, 1'b0, -1, -1);
    run_xfer("single",     1,   16, 1'b0, -1, -1);
    run_xfer("abort",      4,   32, 1'b0,  3, -1);
    run_xfer("after_abort", 4,  32, 1'b0, -1, -1);
    run_xfer("restart",    4,   32, 1'b1, -1,  3);
    run_xfer("floor_cols", 3,   40, 1'b1, -1, -1);
    for (int t = 0; t < 8; t++) begin
      run_xfer("random", int'($urandom_range(0, 5)),
               NC * int'($urandom_range(0, 4)) + int'($urandom_range(0, NC - 1)),
               1'b1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/out_mem_rd_ctrl.md
Name: out_mem_rd_ctrl

Overview:
- Read-side controller for the output memory bank array. The master controller's OUT_STORE phase writes ReLU'd accumulator rows into this memory.
- After a layer completes, this block walks the output memory in linear address order and streams each SYS_COL-wide word to the host or next layer over a valid/ready interface.
- Handles the 1-cycle memory read latency and downstream backpressure with a 2-entry buffer, so no word is dropped or duplicated.

Parameters:
- SYS_COL, 16, number of output memory banks (words per beat); power of two.
- DATA_WIDTH, 16, width of the num_in/num_out size fields.
- ADDR_WIDTH, 16, output memory address width.
- PSUM_WIDTH, 2*DATA_WIDTH, localparam, width of each bank's data.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request to begin draining; sampled only in IDLE
- num_in  in  DATA_WIDTH  number of output rows (M)
- num_out  in  DATA_WIDTH  number of output columns; words per row = num_out >> log2(SYS_COL)
- mem_rd_en  out  SYS_COL  read enable to all banks (all bits identical)
- mem_rd_addr  out  ADDR_WIDTH x [0:SYS_COL-1]  read address (all entries identical)
- mem_rd_data  in  PSUM_WIDTH x [0:SYS_COL-1]  bank data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts the word
- out_data  out  PSUM_WIDTH x [0:SYS_COL-1]  streamed word
- out_last  out  1  marks the final word of the transfer, asserted with out_valid
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (synchronous, rstn=0): state=IDLE. mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0. Buffer, in-flight flag and counters are cleared. Reset mid-transfer aborts it; in-flight read data returning after reset is ignored.
- States:
  - IDLE: on start=1, latch total = num_in * (num_out >> log2(SYS_COL)) at ADDR_WIDTH bits (truncating), and set issue_addr=0, sent_cnt=0.
    - If total==0, go to DONE; no reads are issued.
    - Otherwise go to STREAM with busy=1.
  - STREAM: issue reads and drain the buffer (rules below). When the handshake on the word with out_last=1 completes, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Read issue in STREAM: mem_rd_en=1 in a cycle iff issue_addr < total and (buffer occupancy + in-flight reads − pop this cycle) < 2. The read uses mem_rd_addr=issue_addr, and issue_addr increments on each issue.
  - In-flight reads never exceed 1.
  - Address order is linear 0..total-1, i.e. row r, word-column c at r*(num_out/SYS_COL)+c.
- Buffer: 2-entry FIFO of SYS_COL x PSUM_WIDTH.
  - Push when the read issued the previous cycle returns.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop keeps occupancy unchanged with FIFO order preserved.
  - Overflow cannot occur by construction; verification asserts this.
- Output side: out_valid = buffer non-empty; out_data = head entry, registered or muxed from registers with no combinational path from mem_rd_data.
  - out_last = out_valid & (sent_cnt == total-1).
  - sent_cnt increments per handshake.
  - out_data stays stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready held high, one word per cycle after startup. The first out_valid appears 2 cycles after the start cycle (issue cycle, data-return cycle).

Decomposition:
- Shared package neurex_pkg: state enum {IDLE, STREAM, DONE} as a 2-bit typedef, plus a log2 helper constant for SYS_COL.
- Sub-module: out_skid_fifo, a 2-entry parameterised FIFO with push/pop/occupancy. The controller FSM and address/count logic stay in out_mem_rd_ctrl.

Test Plan:
- Basic stream: SYS_COL=16, num_in=4, num_out=32 (total 8), memory word at address a filled with a, out_ready=1 → 8 beats of data 0..7 on consecutive cycles, out_last on beat 7, done 1 cycle after, busy low after.
- Backpressure: same setup, out_ready toggling 1,0,0,1 pseudo-randomly → exactly 8 beats in order 0..7, out_data stable whenever stalled, mem_rd_en never asserted while occupancy+in-flight would reach 3.
- Zero size: num_in=0 (and separately num_out=8, which gives 0 words) → no mem_rd_en, no out_valid, done pulses within 2 cycles of start.
- Single word: num_in=1, num_out=16 → one beat with out_valid and out_last together, address 0 read once.
- Reset mid-operation: rstn=0 for 1 cycle after 3 of 8 beats → all outputs 0 next cycle; a new start then streams 0..7 from the beginning with no stale word.
- Start while busy: pulse start again during STREAM with different num_in → ignored, original transfer completes with the original count.
